tetris_key_action: RTL and testbench
====================================

Name: tetris_key_action

Overview:
- Sits directly downstream of the PS/2 keyboard decoder.
- Consumes its three key-slot outputs (keyN_on / keyN_code), which are asynchronous to the game clock, and synchronises and filters them.
- Converts held keys into single-cycle game-action strobes on the game clock.
- Horizontal moves and soft drop get delayed auto-shift (DAS) plus auto-repeat (ARR). All other actions fire exactly once per press.

Parameters:
DAS_CYCLES, 8000000, clocks from first strobe to first auto-repeat strobe (160 ms @ 50 MHz); must be >= 2
ARR_CYCLES, 2500000, clocks between subsequent auto-repeat strobes (50 ms @ 50 MHz); must be >= 2
CNT_W, 24, width of DAS/ARR counters; must hold max(DAS_CYCLES, ARR_CYCLES)

Ports:
clk  input  1  game clock
rst  input  1  asynchronous active-low reset
key1_on  input  1  slot 1 held (ENTER/LEFT/RIGHT), async
key1_code  input  8  slot 1 scan code, async
key2_on  input  1  slot 2 held (UP/Z/X), async
key2_code  input  8  slot 2 scan code, async
key3_on  input  1  slot 3 held (DOWN/SHIFT/C/SPACE), async
key3_code  input  8  slot 3 scan code, async
act_start  output  1  strobe, ENTER 0x5A
act_left  output  1  strobe, LEFT 0x6B, repeating
act_right  output  1  strobe, RIGHT 0x74, repeating
act_rot_cw  output  1  strobe, UP 0x75 or X 0x22
act_rot_ccw  output  1  strobe, Z 0x1A
act_soft_drop  output  1  strobe, DOWN 0x72, repeating
act_hard_drop  output  1  strobe, SPACE 0x29
act_hold  output  1  strobe, SHIFT 0x12 or C 0x21
down_held  output  1  level: slot 3 filtered on with code 0x72

Behaviour:
- Reset (rst low, async): all outputs 0. All sync/filter registers set to on=0, code=0xF0. All channel FSMs go to IDLE and counters are cleared. A key already held when reset releases is treated as a new press.

Synchronisation and filtering (per slot, 9 bits {on, code}):
- Three-flop chain: s1<=in, s2<=s1, s3<=s2.
- Filtered value f loads s2 only when s2==s3; otherwise f holds.
- Glitching or incoherent multi-bit transitions never reach the FSM.

Channel active:
- Active when f.on=1 and f.code is one of that slot's listed codes.
- Unlisted codes, or code 0xF0, are treated as released.

Per-slot FSM states, updated on the registered f:
- IDLE: on active, emit the strobe for f.code and go to DAS (repeating code) or HELD (non-repeating code). Load the counter with DAS_CYCLES-1.
- DAS: counter decrements each clock. At 0, emit the strobe, load ARR_CYCLES-1, go to REPEAT.
- REPEAT: counter decrements each clock. At 0, emit the strobe and reload ARR_CYCLES-1.
- HELD: no strobes; wait for release.
- Release (from DAS, REPEAT or HELD): go to IDLE, clear the counter, no strobe. If release coincides with a due strobe, release wins and no strobe fires.
- Code change while still active (e.g. LEFT→RIGHT, overwriting slot 1): treated as a new press. The new code's strobe fires that cycle and the state is re-entered per the IDLE rule, restarting DAS.

Timing:
- Latency: async input change before rising edge 0 → f updated at edge 3 → strobe registered at edge 4, high for exactly one clock.
- Strobe period in REPEAT: exactly ARR_CYCLES clocks.
- First repeat strobe: exactly DAS_CYCLES clocks after the press strobe.

Slot interaction and outputs:
- The three slots are independent. Strobes from different slots may coincide in the same cycle; each output is an OR over slots, but only one slot maps to each action.
- down_held is registered and asserts on the same edge as the first act_soft_drop of a press; it deasserts on the edge the slot-3 FSM leaves DAS or REPEAT.
- All outputs are registered; no combinational path from inputs.

Test Plan (DAS_CYCLES=10, ARR_CYCLES=3):
- Reset/idle: hold rst low 5 clks with all inputs on=0, release → all outputs 0. Then apply key1_on=1, code=0x6B held 40 clks → act_left pulses at edge 4, 14, 17, 20, … every 3 clks; no other output pulses.
- Non-repeat: key2_on=1, code=0x75 held 50 clks → act_rot_cw exactly one pulse at edge 4. Release, then press code 0x1A → exactly one act_rot_ccw pulse.
- Release race: hold key1 LEFT so that a repeat pulse is due at edge N, then drop key1_on so that f clears at edge N-1 → no pulse at edge N or later; FSM in IDLE.
- Code change: LEFT held 12 clks, then key1_code→0x74 with on held → act_right pulse 4 clks after the change; next act_right exactly 10 clks later; no act_left after the change.
- Glitch filter: toggle key3_code bits for a single clock while key3_on=1 with valid code 0x72 → no extra strobe and no DAS restart. down_held stays 1 throughout, then drops within 4 clks of key3_on falling.
- Async reset mid-REPEAT: assert rst for 1 clk during REPEAT → outputs 0 immediately. After release with key still held, a fresh press strobe occurs 4 clks later and DAS restarts (next at +10).

Source files
------------

// File: rtl/tetris_key_action_if.sv
// Key-slot inputs from the PS/2 decoder and game-action outputs.
// master: keyboard side, slave: tetris_key_action.
interface tetris_key_action_if;
   logic       key1_on;
   logic [7:0] key1_code;
   logic       key2_on;
   logic [7:0] key2_code;
   logic       key3_on;
   logic [7:0] key3_code;
   logic       act_start;
   logic       act_left;
   logic       act_right;
   logic       act_rot_cw;
   logic       act_rot_ccw;
   logic       act_soft_drop;
   logic       act_hard_drop;
   logic       act_hold;
   logic       down_held;

   modport master (
      output key1_on, key1_code, key2_on, key2_code,
      output key3_on, key3_code,
      input  act_start, act_left, act_right, act_rot_cw,
      input  act_rot_ccw, act_soft_drop, act_hard_drop,
      input  act_hold, down_held
   );

   modport slave (
      input  key1_on, key1_code, key2_on, key2_code,
      input  key3_on, key3_code,
      output act_start, act_left, act_right, act_rot_cw,
      output act_rot_ccw, act_soft_drop, act_hard_drop,
      output act_hold, down_held
   );
endinterface

// File: rtl/tetris_key_action.sv
// Key slots -> game-action strobes with sync, filter, DAS and ARR.
// Ports: clk, rst (async active-low), kif (slave: keys in, acts out).
module tetris_key_action #(
   parameter int unsigned DAS_CYCLES = 8000000,
   parameter int unsigned ARR_CYCLES = 2500000,
   parameter int unsigned CNT_W      = 24
) (
   input logic                clk,
   input logic                rst,
   tetris_key_action_if.slave kif
);
   typedef struct packed {
      logic       on;
      logic [7:0] code;
   } key_t;

   typedef enum logic [1:0] {
      S_IDLE, S_DAS, S_REPEAT, S_HELD
   } st_e;

   localparam key_t KEY_OFF = '{on: 1'b0, code: 8'hF0};
   localparam logic [CNT_W-1:0] DAS_LD = CNT_W'(DAS_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARR_LD = CNT_W'(ARR_CYCLES - 1);

   function automatic logic code_ok(input int unsigned s,
                                    input logic [7:0] c);
      logic ok;
      ok = 1'b0;
      case (s)
         0: ok = (c == 8'h5A) || (c == 8'h6B) || (c == 8'h74);
         1: ok = (c == 8'h75) || (c == 8'h1A) || (c == 8'h22);
         default: ok = (c == 8'h72) || (c == 8'h12) ||
                       (c == 8'h21) || (c == 8'h29);
      endcase
      return ok;
   endfunction

   function automatic logic code_rep(input logic [7:0] c);
      return (c == 8'h6B) || (c == 8'h74) || (c == 8'h72);
   endfunction

   key_t       in_w [3];
   logic [7:0] fcode_w [3];
   logic [2:0] fire_w;
   logic       dn_w;
   logic [7:0] act_d, act_q;
   logic       dn_d, dn_q;

   assign in_w[0] = {kif.key1_on, kif.key1_code};
   assign in_w[1] = {kif.key2_on, kif.key2_code};
   assign in_w[2] = {kif.key3_on, kif.key3_code};

   for (genvar i = 0; i < 3; i++) begin : g_slot
      key_t s1_q, s2_q, s3_q, f_q;
      key_t s1_d, s2_d, s3_d, f_d;
      st_e  st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [7:0] code_q, code_d;
      logic act, newp, rep, fire;

      // f only moves once two consecutive samples agree, so a
      // multi-bit change caught mid-flight never reaches the FSM.
      always_comb begin
         s1_d = in_w[i];
         s2_d = s1_q;
         s3_d = s2_q;
         f_d  = (s2_q == s3_q) ? s2_q : f_q;
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s1_q <= KEY_OFF;
            s2_q <= KEY_OFF;
            s3_q <= KEY_OFF;
            f_q  <= KEY_OFF;
         end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            f_q  <= f_d;
         end
      end

      always_comb begin
         act  = f_q.on && code_ok(i, f_q.code);
         rep  = (st_q == S_DAS) || (st_q == S_REPEAT);
         // A different code while still held counts as a new press.
         newp = act && ((st_q == S_IDLE) || (f_q.code != code_q));
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            code_q <= 8'hF0;
         end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            code_q <= code_d;
         end
      end

      always_comb begin
         st_d   = st_q;
         cnt_d  = cnt_q;
         code_d = code_q;
         if (!act) begin
            st_d   = S_IDLE;
            cnt_d  = '0;
            code_d = 8'hF0;
         end else if (newp) begin
            st_d   = code_rep(f_q.code) ? S_DAS : S_HELD;
            cnt_d  = DAS_LD;
            code_d = f_q.code;
         end else if (rep) begin
            if (cnt_q == '0) begin
               st_d  = S_REPEAT;
               cnt_d = ARR_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      end

      // Release wins over a due repeat because act gates everything.
      always_comb begin
         fire = act && (newp || (rep && (cnt_q == '0)));
      end

      assign fire_w[i]  = fire;
      assign fcode_w[i] = f_q.code;

      if (i == 2) begin : g_dn
         assign dn_w = (st_d == S_DAS) || (st_d == S_REPEAT);
      end
   end

   always_comb begin
      act_d[0] = fire_w[0] && (fcode_w[0] == 8'h5A);
      act_d[1] = fire_w[0] && (fcode_w[0] == 8'h6B);
      act_d[2] = fire_w[0] && (fcode_w[0] == 8'h74);
      act_d[3] = fire_w[1] && ((fcode_w[1] == 8'h75) ||
                               (fcode_w[1] == 8'h22));
      act_d[4] = fire_w[1] && (fcode_w[1] == 8'h1A);
      act_d[5] = fire_w[2] && (fcode_w[2] == 8'h72);
      act_d[6] = fire_w[2] && (fcode_w[2] == 8'h29);
      act_d[7] = fire_w[2] && ((fcode_w[2] == 8'h12) ||
                               (fcode_w[2] == 8'h21));
      dn_d     = dn_w;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_q <= '0;
         dn_q  <= 1'b0;
      end else begin
         act_q <= act_d;
         dn_q  <= dn_d;
      end
   end

   assign kif.act_start     = act_q[0];
   assign kif.act_left      = act_q[1];
   assign kif.act_right     = act_q[2];
   assign kif.act_rot_cw    = act_q[3];
   assign kif.act_rot_ccw   = act_q[4];
   assign kif.act_soft_drop = act_q[5];
   assign kif.act_hard_drop = act_q[6];
   assign kif.act_hold      = act_q[7];
   assign kif.down_held     = dn_q;
endmodule

// File: tb/tb_tetris_key_action.sv
// Scoreboard bench for tetris_key_action: a press/hold model
// predicts each output vector, a monitor compares per clock.
module tb_tetris_key_action;
   localparam int DAS = 10;
   localparam int ARR = 3;

   typedef struct packed {
      logic       on;
      logic [7:0] code;
   } key_t;

   typedef struct {
      int         edge_n;
      logic [8:0] vec;
   } exp_t;

   localparam key_t OFF = '{on: 1'b0, code: 8'hF0};

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb [$];

   tetris_key_action_if kif();

   tetris_key_action #(
      .DAS_CYCLES(DAS),
      .ARR_CYCLES(ARR),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kif(kif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Model state: last four sampled inputs, filtered value, press info.
   key_t       a0 [3], a1 [3], a2 [3], a3 [3], fm [3];
   bit         pressed [3];
   logic [7:0] pcode [3];
   int         pt [3];

   function automatic key_t K(input logic on, input logic [7:0] c);
      K.on = on;
      K.code = c;
   endfunction

   function automatic bit valid(input int s, input logic [7:0] c);
      if (s == 0) return c == 8'h5A || c == 8'h6B || c == 8'h74;
      if (s == 1) return c == 8'h75 || c == 8'h1A || c == 8'h22;
      return c == 8'h72 || c == 8'h12 || c == 8'h21 || c == 8'h29;
   endfunction

   function automatic bit repeats(input logic [7:0] c);
      return c == 8'h6B || c == 8'h74 || c == 8'h72;
   endfunction

   function automatic int act_bit(input logic [7:0] c);
      case (c)
         8'h5A: return 0;
         8'h6B: return 1;
         8'h74: return 2;
         8'h75, 8'h22: return 3;
         8'h1A: return 4;
         8'h72: return 5;
         8'h29: return 6;
         default: return 7;
      endcase
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         a0[s] = OFF; a1[s] = OFF; a2[s] = OFF; a3[s] = OFF;
         fm[s] = OFF;
         pressed[s] = 0;
         pcode[s] = 8'hF0;
         pt[s] = 0;
      end
   endtask

   // Inputs sampled at edge t; returns outputs expected after edge t+1.
   task automatic model_step(input int t, input key_t v [3],
                             output logic [8:0] vec);
      bit act, fire;
      int d;
      vec = '0;
      for (int s = 0; s < 3; s++) begin
         a3[s] = a2[s]; a2[s] = a1[s]; a1[s] = a0[s]; a0[s] = v[s];
         if (a2[s] == a3[s]) fm[s] = a2[s];
         act = fm[s].on && valid(s, fm[s].code);
         fire = 0;
         if (!act) begin
            pressed[s] = 0;
         end else if (!pressed[s] || fm[s].code != pcode[s]) begin
            pressed[s] = 1;
            pcode[s] = fm[s].code;
            pt[s] = t;
            fire = 1;
         end else if (repeats(fm[s].code)) begin
            d = t - pt[s];
            fire = (d >= DAS) && ((d - DAS) % ARR == 0);
         end
         if (fire) vec[act_bit(fm[s].code)] = 1'b1;
         if (s == 2 && act && fm[s].code == 8'h72) vec[8] = 1'b1;
      end
   endtask

   task automatic step(input key_t k1, input key_t k2, input key_t k3);
      key_t v [3];
      logic [8:0] e;
      int t;
      @(negedge clk);
      #2;
      rst = 1'b1;
      kif.key1_on = k1.on; kif.key1_code = k1.code;
      kif.key2_on = k2.on; kif.key2_code = k2.code;
      kif.key3_on = k3.on; kif.key3_code = k3.code;
      v[0] = k1; v[1] = k2; v[2] = k3;
      t = cyc + 1;
      model_step(t, v, e);
      sb.push_back('{edge_n: t + 1, vec: e});
   endtask

   function automatic logic [8:0] outs();
      return {kif.down_held, kif.act_hold, kif.act_hard_drop,
              kif.act_soft_drop, kif.act_rot_ccw, kif.act_rot_cw,
              kif.act_right, kif.act_left, kif.act_start};
   endfunction

   task automatic do_reset(input int n);
      @(negedge clk);
      #2;
      sb.delete();
      rst = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (outs() !== 9'h0) begin
         miscompares++;
         $display("FAIL async_reset: got %b want 000000000", outs());
      end
      sb.push_back('{edge_n: cyc + 1, vec: 9'h0});
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         #2;
         sb.push_back('{edge_n: cyc + 1, vec: 9'h0});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(OFF, OFF, OFF);
   endtask

   // Monitor: compare every clock for which a prediction exists.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].edge_n < cyc) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL stale_entry: edge %0d unchecked at %0d",
                     e.edge_n, cyc);
         end
         if (sb.size() > 0 && sb[0].edge_n == cyc) begin
            e = sb.pop_front();
            vectors++;
            if (outs() !== e.vec) begin
               miscompares++;
               $display("FAIL outputs edge %0d: got %b want %b",
                        cyc, outs(), e.vec);
            end
         end
      end
   end

   initial begin
      key_t LEFT, RIGHT, UP, ZK, DOWN, cur [3], v [3];
      int   hold [3];
      logic [7:0] tab [3][4];
      int   r;
      LEFT  = K(1'b1, 8'h6B);
      RIGHT = K(1'b1, 8'h74);
      UP    = K(1'b1, 8'h75);
      ZK    = K(1'b1, 8'h1A);
      DOWN  = K(1'b1, 8'h72);
      tab[0] = '{8'h5A, 8'h6B, 8'h74, 8'h6B};
      tab[1] = '{8'h75, 8'h1A, 8'h22, 8'h75};
      tab[2] = '{8'h72, 8'h12, 8'h21, 8'h29};
      kif.key1_on = 1'b0; kif.key1_code = 8'hF0;
      kif.key2_on = 1'b0; kif.key2_code = 8'hF0;
      kif.key3_on = 1'b0; kif.key3_code = 8'hF0;
      model_reset();

      do_reset(5);
      idle(6);
      repeat (40) step(LEFT, OFF, OFF);
      idle(6);
      repeat (50) step(OFF, UP, OFF);
      idle(6);
      repeat (20) step(OFF, ZK, OFF);
      idle(6);
      for (int n = 11; n <= 20; n++) begin
         repeat (n) step(LEFT, OFF, OFF);
         idle(5);
      end
      repeat (12) step(LEFT, OFF, OFF);
      repeat (25) step(RIGHT, OFF, OFF);
      idle(6);
      repeat (15) step(OFF, OFF, DOWN);
      step(OFF, OFF, K(1'b1, 8'h72 ^ 8'h0C));
      repeat (15) step(OFF, OFF, DOWN);
      step(OFF, OFF, K(1'b0, 8'h72));
      repeat (10) step(OFF, OFF, DOWN);
      idle(6);
      repeat (20) step(LEFT, OFF, OFF);
      do_reset(1);
      repeat (20) step(LEFT, OFF, OFF);
      idle(6);

      for (int s = 0; s < 3; s++) begin
         cur[s] = OFF;
         hold[s] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int s = 0; s < 3; s++) begin
            if (hold[s] == 0) begin
               r = $urandom_range(0, 9);
               if (r < 6)
                  cur[s] = K(1'b1, tab[s][$urandom_range(0, 3)]);
               else if (r == 6)
                  cur[s] = K(1'b1, 8'($urandom_range(0, 255)));
               else if (r == 7)
                  cur[s] = K(1'b1, 8'hF0);
               else
                  cur[s] = OFF;
               hold[s] = $urandom_range(1, 25);
            end
            hold[s]--;
            v[s] = cur[s];
            if ($urandom_range(0, 30) == 0)
               v[s] = cur[s] ^ 9'($urandom_range(1, 511));
         end
         if ($urandom_range(0, 499) == 0)
            do_reset($urandom_range(1, 3));
         step(v[0], v[1], v[2]);
      end
      idle(8);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
